// File: rtl/io_pkg.sv
// io_pkg: shared defaults and types for the host-side terminal peripheral.
//   DATA_W_DEF      - default word width (matches the CPU's INPR/OUTR).
//   FIFO_DEPTH_DEF  - default input FIFO depth (power of 2, >= 2).
//   out_state_t     - output path state: word slot free or word pending for host.
package io_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [0:0] {
    OUT_IDLE = 1'b0,
    OUT_BUSY = 1'b1
  } out_state_t;

endpackage : io_pkg

// File: rtl/io_fifo.sv
// io_fifo: synchronous FIFO buffering host input words for the CPU.
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-low reset
//   push, wr_data     - write request and data (ignored while full)
//   pop               - read request (ignored while empty)
//   full, empty       - occupancy flags derived from the registered count
//   head              - oldest entry, forced to zero while empty
module io_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    count_r;
  logic [PTR_W:0]    count_nx_s;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full      = (count_r == (PTR_W+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Occupancy update: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_nx_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nx_s = count_r + (PTR_W+1)'(1);
      2'b01:   count_nx_s = count_r - (PTR_W+1)'(1);
      default: count_nx_s = count_r;
    endcase
  end

  // Storage, pointers and count; reset discards every buffered word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nx_s;
    end
  end

  // Head presentation: stale storage is never shown once the FIFO is empty.
  always_comb begin
    head = '0;
    if (empty) begin
      head = '0;
    end else begin
      head = mem_r[rd_ptr_r];
    end
  end

endmodule : io_fifo

// File: rtl/io_terminal.sv
// io_terminal: host-side terminal at the far end of the CPU INPR/OUTR port.
// Input path buffers host words in io_fifo and presents the head on inpr_data
// with fgi. Output path captures OUTR words on out_load into a holding register
// and hands them to the host with a valid/ready handshake; fgo marks the slot
// free. irq = ien & (fgi | fgo).
// Ports:
//   clk, reset                                - clock, async active-low reset
//   host_in_data/valid/ready                  - host -> FIFO word stream
//   inpr_data, fgi, inp_ack                   - CPU input side (ack pops head)
//   outr_data, out_load, fgo                  - CPU output side
//   host_out_data/valid/ready                 - holding register -> host
//   ien, irq                                  - interrupt enable / request
//   err_clr, out_overrun                      - sticky overrun flag and clear
module io_terminal
  import io_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] host_in_data,
  input  logic              host_in_valid,
  output logic              host_in_ready,
  output logic [DATA_W-1:0] inpr_data,
  output logic              fgi,
  input  logic              inp_ack,
  input  logic [DATA_W-1:0] outr_data,
  input  logic              out_load,
  output logic              fgo,
  output logic [DATA_W-1:0] host_out_data,
  output logic              host_out_valid,
  input  logic              host_out_ready,
  input  logic              ien,
  output logic              irq,
  input  logic              err_clr,
  output logic              out_overrun
);

  logic              fifo_full_s;
  logic              fifo_empty_s;
  out_state_t        state_r;
  out_state_t        state_nx_s;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] hold_nx_s;
  logic              overrun_r;
  logic              overrun_nx_s;

  io_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (host_in_valid),
    .wr_data (host_in_data),
    .pop     (inp_ack),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .head    (inpr_data)
  );

  assign host_in_ready  = ~fifo_full_s;
  assign fgi            = ~fifo_empty_s;
  assign fgo            = (state_r == OUT_IDLE);
  assign host_out_valid = (state_r == OUT_BUSY);
  assign host_out_data  = hold_r;
  assign out_overrun    = overrun_r;
  assign irq            = ien & (fgi | fgo);

  // Output FSM next-state, holding register load and overrun tracking.
  always_comb begin
    state_nx_s   = state_r;
    hold_nx_s    = hold_r;
    overrun_nx_s = overrun_r;
    case (state_r)
      OUT_IDLE: begin
        if (out_load) begin
          state_nx_s = OUT_BUSY;
          hold_nx_s  = outr_data;
        end else begin
          state_nx_s = OUT_IDLE;
        end
      end
      OUT_BUSY: begin
        if (host_out_ready) begin
          state_nx_s = OUT_IDLE;
        end else begin
          state_nx_s = OUT_BUSY;
        end
      end
      default: begin
        state_nx_s = OUT_IDLE;
      end
    endcase
    // A load while busy (even on the draining cycle) is dropped; set beats clear.
    if (out_load && (state_r == OUT_BUSY)) begin
      overrun_nx_s = 1'b1;
    end else if (err_clr) begin
      overrun_nx_s = 1'b0;
    end else begin
      overrun_nx_s = overrun_r;
    end
  end

  // Output path state, holding register and sticky overrun flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= OUT_IDLE;
      hold_r    <= '0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      hold_r    <= hold_nx_s;
      overrun_r <= overrun_nx_s;
    end
  end

endmodule : io_terminal
